mem_port_arbiter: RTL and testbench

Arbitrates the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage MIPS pipeline onto one shared single-port memory with a variable-latency req/ack handshake. It sits between the pipeline stages and the unified memory. Its per-port stall outputs feed the pipeline controller's `if_en` and `mem_en` gating. Data accesses have priority, and a starvation counter bounds how long instruction fetch can be locked out.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and the MEM data port onto one single-port memory
// with a req/ack handshake. Define MEM_ARB_PERF_EN to add grant/conflict counters.
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_stall,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0] perf_i_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_conflicts
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_e;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_e      state_q, state_d;
   owner_e      owner_q, owner_d;
   logic [3:0]  starve_q, starve_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic starve_hit;
   logic grant_d;
   logic grant_i;

   // Data wins a tie unless fetch has already lost STARVE_MAX times in a row.
   assign starve_hit = (starve_q == STARVE_LIM);
   assign grant_d    = (state_q == ST_IDLE) && d_req && !(if_req && starve_hit);
   assign grant_i    = (state_q == ST_IDLE) && if_req && !grant_d;

   // State register
   always_ff @(posedge clk) begin
      // NOTE: state elements use non-blocking assignment so every register samples
      // pre-edge values, independent of statement order.
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_D;
         starve_q   <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         starve_q   <= starve_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: every target gets a hold default first, so no path can infer a latch.
      state_d    = state_q;
      owner_d    = owner_q;
      starve_d   = starve_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant_d) begin
               state_d = ST_ISSUE;
               owner_d = OWN_D;
               we_d    = d_we;
               addr_d  = d_addr;
               wdata_d = d_wdata;
               if (!if_req)
                  starve_d = '0;
               else if (!starve_hit)
                  starve_d = starve_q + 4'd1;
            end else if (grant_i) begin
               state_d  = ST_ISSUE;
               owner_d  = OWN_I;
               we_d     = 1'b0;
               addr_d   = if_addr;
               wdata_d  = '0;
               starve_d = '0;
            end
         end
         ST_ISSUE: begin
            if (mem_ack) begin
               state_d = ST_RESP;
               if (owner_q == OWN_D)
                  d_rdata_d = mem_rdata;
               else
                  if_rdata_d = mem_rdata;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      mem_req = 1'b0;
      if_ack  = 1'b0;
      d_ack   = 1'b0;
      unique case (state_q)
         ST_ISSUE: mem_req = 1'b1;
         ST_RESP: begin
            if (owner_q == OWN_D)
               d_ack = 1'b1;
            else
               if_ack = 1'b1;
         end
         default: ;
      endcase
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_stall  = if_req & ~if_ack;
   assign d_stall   = d_req & ~d_ack;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_i_q;
   logic [31:0] perf_d_q;
   logic [31:0] perf_c_q;
   logic        conflict_now;

   // A conflict is a tied IDLE sample or a cycle where one port waits on the other.
   assign conflict_now = ((state_q == ST_IDLE) && if_req && d_req) ||
                         ((state_q != ST_IDLE) &&
                          (((owner_q == OWN_D) && if_stall) ||
                           ((owner_q == OWN_I) && d_stall)));

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_i_q <= '0;
         perf_d_q <= '0;
         perf_c_q <= '0;
      end else begin
         if (grant_i && (perf_i_q != '1))
            perf_i_q <= perf_i_q + 32'd1;
         if (grant_d && (perf_d_q != '1))
            perf_d_q <= perf_d_q + 32'd1;
         if (conflict_now && (perf_c_q != '1))
            perf_c_q <= perf_c_q + 32'd1;
      end
   end

   assign perf_i_grants  = perf_i_q;
   assign perf_d_grants  = perf_d_q;
   assign perf_conflicts = perf_c_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected memory
// transactions and acks; a memory model and an ack monitor pop and compare.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_stall;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'hBAD0BAD0;
`ifdef MEM_ARB_PERF_EN
   logic [31:0] perf_i_grants;
   logic [31:0] perf_d_grants;
   logic [31:0] perf_conflicts;
`endif

   mem_port_arbiter #(.STARVE_MAX(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ack    (if_ack),
      .if_rdata  (if_rdata),
      .if_stall  (if_stall),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .d_stall   (d_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_i_grants  (perf_i_grants),
      .perf_d_grants  (perf_d_grants),
      .perf_conflicts (perf_conflicts)
`endif
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
   } mem_exp_t;

   typedef struct {
      logic        is_d;
      logic        chk_data;
      logic [31:0] data;
   } resp_exp_t;

   mem_exp_t  mem_q[$];
   resp_exp_t resp_q[$];

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s", name);
   endtask

   task automatic expect_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int waits);
      mem_q.push_back('{we: we, addr: addr, wdata: wdata, rdata: rdata, waits: waits});
      resp_q.push_back('{is_d: 1'b1, chk_data: !we, data: rdata});
   endtask

   task automatic expect_i(input logic [31:0] addr, input logic [31:0] rdata, input int waits);
      mem_q.push_back('{we: 1'b0, addr: addr, wdata: 32'h0, rdata: rdata, waits: waits});
      resp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: rdata});
   endtask

   // Memory model: acks after the expected number of wait cycles, checks fields.
   logic     mem_active = 1'b0;
   int       mem_cnt    = 0;
   mem_exp_t mem_cur;

   always @(negedge clk) begin
      if (mem_ack) begin
         mem_ack    = 1'b0;
         mem_rdata  = 32'hBAD0BAD0;
         mem_active = 1'b0;
      end else if (!mem_req) begin
         mem_active = 1'b0;
      end else begin
         if (!mem_active) begin
            mem_active = 1'b1;
            mem_cnt    = 0;
            if (mem_q.size() == 0) begin
               fail("mem_unexpected_req");
               mem_cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, rdata: 32'h0, waits: 0};
            end else begin
               mem_cur = mem_q.pop_front();
               check("mem_we", mem_we, mem_cur.we);
               check("mem_addr", mem_addr, mem_cur.addr);
               if (mem_cur.we) check("mem_wdata", mem_wdata, mem_cur.wdata);
            end
         end else begin
            check("mem_we_stable", mem_we, mem_cur.we);
            check("mem_addr_stable", mem_addr, mem_cur.addr);
            if (mem_cur.we) check("mem_wdata_stable", mem_wdata, mem_cur.wdata);
         end
         if (mem_cnt == mem_cur.waits) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_cur.rdata;
         end
         mem_cnt++;
      end
   end

   // Ack monitor: every ack must match the next expected response.
   always @(negedge clk) begin
      resp_exp_t r;
      if (if_ack && d_ack) begin
         fail("both_acks");
      end else if (if_ack || d_ack) begin
         if (resp_q.size() == 0) begin
            fail("unexpected_ack");
         end else begin
            r = resp_q.pop_front();
            check("ack_port_is_d", d_ack, r.is_d);
            if (r.chk_data) begin
               if (r.is_d) check("d_rdata", d_rdata, r.data);
               else        check("if_rdata", if_rdata, r.data);
            end
         end
      end
   end

   task automatic drive_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat);
      @(negedge clk);
      d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!d_ack) check("d_stall_wait", d_stall, 1);
      end while (!d_ack && lat < 200);
      if (!d_ack) fail("d_ack_timeout");
      else        check("d_stall_at_ack", d_stall, 0);
      d_req = 1'b0;
   endtask

   task automatic drive_i(input logic [31:0] addr, output int lat);
      @(negedge clk);
      if_addr = addr; if_req = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!if_ack) check("if_stall_wait", if_stall, 1);
      end while (!if_ack && lat < 200);
      if (!if_ack) fail("if_ack_timeout");
      else         check("if_stall_at_ack", if_stall, 0);
      if_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int lat_d, lat_i;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_if_ack", if_ack, 0);
      check("rst_d_ack", d_ack, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_if_stall_idle", if_stall, 0);
      if_req = 1'b1;
      #1 check("rst_if_stall_follows", if_stall, 1);
      if_req = 1'b0;

      // Conflict from reset release: D first, I three cycles later
      @(negedge clk);
      rst = 1'b0;
      expect_d(1'b0, 32'h300, 32'h0, 32'h1111_2222, 0);
      expect_i(32'h400, 32'h0000_0020, 0);
      fork
         drive_d(1'b0, 32'h300, 32'h0, lat_d);
         drive_i(32'h400, lat_i);
      join
      check("conflict_d_latency", lat_d, 2);
      check("conflict_i_latency", lat_i, 5);
`ifdef MEM_ARB_PERF_EN
      check("perf_d_grants", perf_d_grants, 1);
      check("perf_i_grants", perf_i_grants, 1);
      check("perf_conflicts_nonzero", 32'(perf_conflicts >= 32'd1), 1);
`endif

      // Lone fetch, immediate memory ack
      expect_i(32'h100, 32'h8C01_0004, 0);
      drive_i(32'h100, lat_i);
      check("fetch_latency", lat_i, 2);

      // Store with three wait cycles
      expect_d(1'b1, 32'h200, 32'hDEAD_BEEF, 32'h5555_AAAA, 3);
      drive_d(1'b1, 32'h200, 32'hDEAD_BEEF, lat_d);
      check("store_latency", lat_d, 5);

      // Starvation: 4 D grants, then I, then D resumes
      for (int n = 0; n < 4; n++)
         expect_d(1'b0, 32'h500 + 32'(4 * n), 32'h0, 32'hD000_0000 + 32'(n), 0);
      expect_i(32'h600, 32'h1234_5678, 0);
      for (int n = 4; n < 6; n++)
         expect_d(1'b0, 32'h500 + 32'(4 * n), 32'h0, 32'hD000_0000 + 32'(n), 0);
      fork
         begin
            int lat_s;
            for (int n = 0; n < 6; n++)
               drive_d(1'b0, 32'h500 + 32'(4 * n), 32'h0, lat_s);
         end
         drive_i(32'h600, lat_i);
      join
      check("starve_i_latency", lat_i, 14);
      check("starve_cnt_cleared", 32'(dut.starve_q), 0);

      // Reset while the memory is still busy
      mem_q.push_back('{we: 1'b0, addr: 32'h700, wdata: 32'h0, rdata: 32'h0, waits: 10});
      @(negedge clk);
      d_we = 1'b0; d_addr = 32'h700; d_wdata = 32'h0; d_req = 1'b1;
      @(negedge clk);
      check("midop_mem_req_before", mem_req, 1);
      rst = 1'b1;
      @(negedge clk);
      check("midop_mem_req_after", mem_req, 0);
      check("midop_d_ack", d_ack, 0);
      check("midop_state_idle", 32'(dut.state_q), 0);
`ifdef MEM_ARB_PERF_EN
      check("perf_i_rst", perf_i_grants, 0);
      check("perf_d_rst", perf_d_grants, 0);
      check("perf_c_rst", perf_conflicts, 0);
`endif
      d_req = 1'b0;
      rst   = 1'b0;
      repeat (2) @(negedge clk);
      check("midop_no_late_ack", d_ack, 0);

      // Fresh traffic after reset, then rdata hold across the other port
      expect_d(1'b0, 32'h704, 32'h0, 32'hCAFE_F00D, 1);
      drive_d(1'b0, 32'h704, 32'h0, lat_d);
      check("fresh_load_latency", lat_d, 3);
      expect_i(32'h108, 32'h2402_0005, 0);
      drive_i(32'h108, lat_i);
      check("fresh_fetch_latency", lat_i, 2);
      repeat (3) @(negedge clk);
      check("d_rdata_hold", d_rdata, 32'hCAFE_F00D);
      check("if_rdata_hold", if_rdata, 32'h2402_0005);

      check("mem_q_drained", 32'(mem_q.size()), 0);
      check("resp_q_drained", 32'(resp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
